// File: rtl/md_unit.sv
// HI/LO multiply-divide unit for the MIPS E stage: multi-cycle mult/div, single-cycle mthi/mtlo.
// Define MD_FLUSH_EN to add the iflush port that cancels an in-flight operation.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        iclk,
    input  logic        ireset_n,
    input  logic        istart,
    input  logic [2:0]  iop,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    input  logic        iMD_sel,
`ifdef MD_FLUSH_EN
    input  logic        iflush,
`endif
    output logic        oBusy,
    output logic [31:0] oMDout
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} mdState_e;

    mdState_e      state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   phi_q, plo_q;
    logic [31:0]   hi_q, lo_q;
    logic          busy_q;
    logic          flush;

`ifdef MD_FLUSH_EN
    assign flush = iflush;
`else
    assign flush = 1'b0;
`endif

    logic [63:0]        mulSigned, mulUnsigned;
    logic signed [31:0] dividendS, divisorS, divQuoS, divRemS;
    logic [31:0]        divQuoU, divRemU;
    logic               divOvf;

    // Sign-extending to 64 bits makes the low 64 product bits correct for signed operands.
    assign mulSigned   = {{32{iA[31]}}, iA} * {{32{iB[31]}}, iB};
    assign mulUnsigned = {32'd0, iA} * {32'd0, iB};

    assign dividendS = $signed(iA);
    assign divisorS  = $signed(iB);
    assign divQuoS   = dividendS / divisorS;
    assign divRemS   = dividendS % divisorS;
    assign divQuoU   = iA / iB;
    assign divRemU   = iA % iB;
    assign divOvf    = (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);

    logic          startRun_d;
    logic [31:0]   startHi_d, startLo_d;
    logic [CW-1:0] startCnt_d;

    always_comb begin
        startRun_d = 1'b0;
        startHi_d  = '0;
        startLo_d  = '0;
        startCnt_d = '0;
        case (iop)
            OP_MULT: begin
                {startHi_d, startLo_d} = mulSigned;
                startCnt_d = MULT_CNT;
                startRun_d = 1'b1;
            end
            OP_MULTU: begin
                {startHi_d, startLo_d} = mulUnsigned;
                startCnt_d = MULT_CNT;
                startRun_d = 1'b1;
            end
            OP_DIV: begin
                // A zero divisor leaves the unit idle and HI/LO untouched.
                if (iB != '0) begin
                    startCnt_d = DIV_CNT;
                    startRun_d = 1'b1;
                    if (divOvf) begin
                        startHi_d = '0;
                        startLo_d = 32'h8000_0000;
                    end else begin
                        startHi_d = divRemS;
                        startLo_d = divQuoS;
                    end
                end
            end
            OP_DIVU: begin
                if (iB != '0) begin
                    startCnt_d = DIV_CNT;
                    startRun_d = 1'b1;
                    startHi_d  = divRemU;
                    startLo_d  = divQuoU;
                end
            end
            default: ;
        endcase
    end

    // The pending result sits in phi_q/plo_q and only reaches HI/LO when the counter expires.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (istart) begin
                        if (startRun_d) begin
                            phi_q   <= startHi_d;
                            plo_q   <= startLo_d;
                            cnt_q   <= startCnt_d;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else if (iop == OP_MTHI) begin
                            hi_q <= iA;
                        end else if (iop == OP_MTLO) begin
                            lo_q <= iA;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q == CW'(1)) begin
                        hi_q    <= phi_q;
                        lo_q    <= plo_q;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oBusy  = busy_q;
    assign oMDout = iMD_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed and randomized checks of md_unit against a plain-arithmetic HI/LO model.
// Define MD_FLUSH_EN to also exercise the flush port.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        iclk = 1'b0;
    logic        ireset_n;
    logic        istart;
    logic [2:0]  iop;
    logic [31:0] iA, iB;
    logic        iMD_sel;
    logic        oBusy;
    logic [31:0] oMDout;
`ifdef MD_FLUSH_EN
    logic        iflush;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mHi, mLo;
    logic [31:0] rdHi, rdLo;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .iclk    (iclk),
        .ireset_n(ireset_n),
        .istart  (istart),
        .iop     (iop),
        .iA      (iA),
        .iB      (iB),
        .iMD_sel (iMD_sel),
`ifdef MD_FLUSH_EN
        .iflush  (iflush),
`endif
        .oBusy   (oBusy),
        .oMDout  (oMDout)
    );

    always #5 iclk = ~iclk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic readHiLo(output logic [31:0] h, output logic [31:0] l);
        iMD_sel = 1'b0;
        #1 h = oMDout;
        iMD_sel = 1'b1;
        #1 l = oMDout;
    endtask

    task automatic nextCycle();
        @(posedge iclk);
        #1;
    endtask

    // Architectural result of an MD op, derived with 64-bit integer arithmetic.
    function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output bit starts, output logic [31:0] h, output logic [31:0] l,
                                     output int lat);
        longint sa, sb, q, r;
        longint unsigned ua, ub, p;
        starts = 1'b0; h = '0; l = '0; lat = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT:  begin p = longint'(sa * sb); {h, l} = p; starts = 1'b1; lat = MULT_N; end
            OP_MULTU: begin p = ua * ub;           {h, l} = p; starts = 1'b1; lat = MULT_N; end
            OP_DIV: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                l = q[31:0]; h = r[31:0]; starts = 1'b1; lat = DIV_N;
            end
            OP_DIVU: if (b != 0) begin
                l = 32'(ua / ub); h = 32'(ua % ub); starts = 1'b1; lat = DIV_N;
            end
            default: ;
        endcase
    endfunction

    // Issues one op from idle, checks busy timing and HI/LO visibility, and updates the model.
    // injectAt > 0 drives an MTLO 0xABCD during that busy cycle; it must be ignored.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int injectAt);
        bit          starts;
        logic [31:0] eh, el;
        int          lat;
        refModel(op, a, b, starts, eh, el, lat);
        istart = 1'b1; iop = op; iA = a; iB = b;
        nextCycle();
        istart = 1'b0; iop = OP_NONE;
        if (starts) begin
            for (int k = 1; k <= lat; k++) begin
                checkOutput({tag, "_busy"}, {31'd0, oBusy}, 32'd1);
                readHiLo(rdHi, rdLo);
                checkOutput({tag, "_hold_hi"}, rdHi, mHi);
                checkOutput({tag, "_hold_lo"}, rdLo, mLo);
                if (k == injectAt) begin
                    istart = 1'b1; iop = OP_MTLO; iA = 32'h0000_ABCD;
                end
                nextCycle();
                istart = 1'b0; iop = OP_NONE;
            end
            mHi = eh; mLo = el;
        end else if (op == OP_MTHI) begin
            mHi = a;
        end else if (op == OP_MTLO) begin
            mLo = a;
        end
        checkOutput({tag, "_idle"}, {31'd0, oBusy}, 32'd0);
        readHiLo(rdHi, rdLo);
        checkOutput({tag, "_hi"}, rdHi, mHi);
        checkOutput({tag, "_lo"}, rdLo, mLo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        ireset_n = 1'b0; istart = 1'b0; iop = OP_NONE; iA = '0; iB = '0; iMD_sel = 1'b0;
`ifdef MD_FLUSH_EN
        iflush = 1'b0;
`endif
        mHi = '0; mLo = '0;
        #12;
        checkOutput("reset_busy", {31'd0, oBusy}, 32'd0);
        readHiLo(rdHi, rdLo);
        checkOutput("reset_hi", rdHi, 32'd0);
        checkOutput("reset_lo", rdLo, 32'd0);
        ireset_n = 1'b1;
        nextCycle();

        applyStimulus("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 0);
        checkOutput("plan1_hi", rdHi, 32'hFFFF_FFFF);
        checkOutput("plan1_lo", rdLo, 32'hFFFF_FFF1);

        applyStimulus("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        checkOutput("plan2_hi", rdHi, 32'h0000_0001);
        checkOutput("plan2_lo", rdLo, 32'hFFFF_FFFE);

        applyStimulus("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        checkOutput("plan3_div_hi", rdHi, 32'hFFFF_FFFF);
        checkOutput("plan3_div_lo", rdLo, 32'hFFFF_FFFD);
        applyStimulus("divu", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 0);
        checkOutput("plan3_divu_hi", rdHi, 32'h0000_0001);
        checkOutput("plan3_divu_lo", rdLo, 32'h7FFF_FFFC);

        applyStimulus("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        checkOutput("ovf_hi", rdHi, 32'h0000_0000);
        checkOutput("ovf_lo", rdLo, 32'h8000_0000);

        applyStimulus("mthi", OP_MTHI, 32'h11, 32'd0, 0);
        applyStimulus("mtlo", OP_MTLO, 32'h22, 32'd0, 0);
        applyStimulus("divu_zero", OP_DIVU, 32'd7, 32'd0, 0);
        checkOutput("plan4_hi", rdHi, 32'h11);
        checkOutput("plan4_lo", rdLo, 32'h22);
        applyStimulus("div_zero", OP_DIV, 32'd7, 32'd0, 0);
        applyStimulus("reserved", 3'd7, 32'h1234, 32'h5678, 0);

        applyStimulus("mult_inject", OP_MULT, 32'd1234, 32'd5678, 2);
        checkOutput("plan5_lo", rdLo, 32'd7006652);

        // Reset pulse in busy cycle 3 of a DIV aborts it with no later commit.
        istart = 1'b1; iop = OP_DIV; iA = 32'd100; iB = 32'd7;
        nextCycle();
        istart = 1'b0; iop = OP_NONE;
        nextCycle();
        nextCycle();
        checkOutput("rst_mid_busy_before", {31'd0, oBusy}, 32'd1);
        ireset_n = 1'b0;
        #1;
        mHi = '0; mLo = '0;
        checkOutput("rst_mid_busy", {31'd0, oBusy}, 32'd0);
        readHiLo(rdHi, rdLo);
        checkOutput("rst_mid_hi", rdHi, 32'd0);
        checkOutput("rst_mid_lo", rdLo, 32'd0);
        ireset_n = 1'b1;
        for (int k = 0; k < DIV_N + 2; k++) nextCycle();
        checkOutput("rst_after_busy", {31'd0, oBusy}, 32'd0);
        readHiLo(rdHi, rdLo);
        checkOutput("rst_after_hi", rdHi, 32'd0);
        checkOutput("rst_after_lo", rdLo, 32'd0);

`ifdef MD_FLUSH_EN
        applyStimulus("pre_flush_hi", OP_MTHI, 32'h5555_0001, 32'd0, 0);
        applyStimulus("pre_flush_lo", OP_MTLO, 32'h5555_0002, 32'd0, 0);
        istart = 1'b1; iop = OP_DIV; iA = 32'd99; iB = 32'd4;
        nextCycle();
        istart = 1'b0; iop = OP_NONE;
        for (int k = 1; k < 4; k++) nextCycle();
        checkOutput("flush_busy_before", {31'd0, oBusy}, 32'd1);
        iflush = 1'b1;
        nextCycle();
        iflush = 1'b0;
        checkOutput("flush_busy", {31'd0, oBusy}, 32'd0);
        for (int k = 0; k < DIV_N + 2; k++) nextCycle();
        checkOutput("flush_after_busy", {31'd0, oBusy}, 32'd0);
        readHiLo(rdHi, rdLo);
        checkOutput("flush_hi", rdHi, mHi);
        checkOutput("flush_lo", rdLo, mLo);
        iflush = 1'b1; istart = 1'b1; iop = OP_MTHI; iA = 32'hDEAD_BEEF;
        nextCycle();
        iflush = 1'b0; istart = 1'b0; iop = OP_NONE;
        readHiLo(rdHi, rdLo);
        checkOutput("flush_mthi_hi", rdHi, mHi);
`endif

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (($urandom_range(0, 9) == 0) && (rop == OP_DIV)) begin
                ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            applyStimulus("rand", rop, ra, rb, ($urandom_range(0, 2) == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu over a fixed multi-cycle latency, and executes mthi/mtlo in a single cycle.
- Holds the architectural HI/LO registers and supplies the mfhi/mflo read value to the E-stage result mux.
- Its oBusy output feeds the hazard unit, which stalls D-stage MD instructions while an operation is pending.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
iclk  input  1  clock; all state updates on rising edge
ireset_n  input  1  asynchronous, active-low reset
istart  input  1  E-stage MD instruction valid this cycle
iop  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
iA  input  32  rs value (forwarded)
iB  input  32  rt value (forwarded)
iMD_sel  input  1  read select: 0 = HI (MD_SEL_HI), 1 = LO (MD_SEL_LO)
oBusy  output  1  operation in flight
oMDout  output  32  committed HI or LO, per iMD_sel

Behaviour:
- Reset (ireset_n low, asynchronous):
  - HI, LO, pending HI/LO, counter and state all go to 0; oBusy = 0; oMDout = 0.
  - Reset asserted mid-operation aborts the operation; the result is never committed.
- States: IDLE and RUN.
- IDLE, istart = 1:
  - MULT/MULTU: {pHI,pLO} = 64-bit product of iA and iB (signed for MULT, unsigned for MULTU). Counter = MULT_CYCLES. Go to RUN.
  - DIV/DIVU: pLO = quotient, pHI = remainder (signed for DIV, unsigned for DIVU). The quotient truncates toward zero and the remainder takes the dividend's sign. Counter = DIV_CYCLES. Go to RUN.
  - DIV/DIVU with iB = 0: no operation starts, HI/LO stay unchanged, oBusy stays 0.
  - DIV with iA = 0x80000000 and iB = 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - MTHI: HI <= iA at this edge. MTLO: LO <= iA at this edge. Stay in IDLE.
  - NONE or reserved: no effect.
- RUN:
  - oBusy = 1, registered. It rises on the edge after the start cycle and stays high for exactly N cycles (MULT_CYCLES or DIV_CYCLES).
  - Counter decrements each cycle. On the edge where it reaches 0: HI <= pHI, LO <= pLO, oBusy <= 0, go to IDLE.
  - istart while in RUN (any op, including MTHI/MTLO) is ignored and raises no error. The hazard unit guarantees this does not occur.
- oMDout is combinational from the committed HI/LO and iMD_sel. The pending result is never visible before commit.
- mfhi/mflo reads HI/LO as written at the previous edge; there is no bypass of a same-cycle MTHI/MTLO.
- The hazard unit must treat (istart && op in {MULT..DIVU}) || oBusy as busy. That term is produced outside this block.

Optional Feature:
MD_FLUSH_EN:
- When defined, the block adds input port iflush (1 bit).
- iflush = 1 in any cycle forces state IDLE, oBusy = 0 and counter = 0 at the next edge, discarding the pending result. HI/LO keep their prior values.
- iflush has priority over istart in the same cycle: a start in that cycle, including MTHI/MTLO, is dropped.
- This supports exception flush in the next project stage.
- When not defined, the port is absent and no operation can be cancelled except by reset.

Test Plan:
1. MULT iA = 0xFFFFFFFD (-3), iB = 5 -> oBusy high for 5 cycles starting the edge after start, then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; oMDout unchanged until the commit edge.
2. MULTU iA = 0xFFFFFFFF, iB = 2 -> after 5 busy cycles HI = 0x00000001, LO = 0xFFFFFFFE.
3. DIV iA = 0xFFFFFFF9 (-7), iB = 2 -> oBusy high for 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU same operands -> LO = 0x7FFFFFFC, HI = 1.
4. DIVU iA = 7, iB = 0 with HI = 0x11, LO = 0x22 preloaded via MTHI/MTLO -> oBusy stays 0; HI = 0x11, LO = 0x22 read back with iMD_sel = 0/1.
5. MULT started, MTLO 0xABCD issued in busy cycle 2 -> MTLO ignored; the final LO is the product. ireset_n pulsed low in busy cycle 3 of a later DIV -> oBusy = 0, HI = LO = 0 immediately, no commit afterwards.
6. (MD_FLUSH_EN) DIV started, iflush = 1 in busy cycle 4 -> oBusy low at the next edge, HI/LO keep their pre-DIV values. iflush and istart(MTHI) in the same cycle -> HI unchanged.
